sample_feeder: RTL
==================

SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter WORD_LENGTH, default 16, sample width in bits.
REQ-002 Parameter FIFO_DEPTH, default 8, sample buffer depth; power of two, >= 2.
REQ-003 Parameter SYSTEM_FREQUENCY, default 100000000, clock_i frequency in Hz.
REQ-004 Parameter SAMPLE_RATE, default 48000, output sample rate in Hz; TICK_DIV = SYSTEM_FREQUENCY/SAMPLE_RATE SHALL be >= WORD_LENGTH+4.
REQ-005 clock_i  input  1  system clock; all logic on rising edge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 sample_i  input  WORD_LENGTH  audio sample from producer.
REQ-008 sample_valid_i  input  1  sample_i valid this cycle.
REQ-009 sample_ready_o  output  1  buffer can accept a sample this cycle.
REQ-010 data_o  output  WORD_LENGTH  word presented to the downstream serializer.
REQ-011 enable_o  output  1  request to the serializer to shift data_o.
REQ-012 done_i  input  1  one-cycle pulse from the serializer: word fully shifted.
REQ-013 underrun_o  output  1  one-cycle pulse: tick occurred with empty buffer.
REQ-014 late_o  output  1  one-cycle pulse: tick occurred while a word was still shifting.
REQ-015 level_o  output  clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-016 Buffer SHALL be a FIFO of FIFO_DEPTH words; write on sample_valid_i && sample_ready_o.
REQ-017 sample_ready_o SHALL be 1 iff reset_i is 0 and level_o < FIFO_DEPTH; it SHALL NOT depend on a same-cycle pop.
REQ-018 Write and pop in the same cycle SHALL both take effect; level_o unchanged; FIFO order preserved.
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 and wrap; a tick is the cycle in which the counter equals TICK_DIV-1 (one tick per TICK_DIV cycles).
REQ-020 FSM states: IDLE, SHIFT.
REQ-021 IDLE, tick, level_o > 0: pop head into data_o, go SHIFT; data_o and enable_o=1 visible the cycle after the tick.
REQ-022 IDLE, tick, level_o == 0: load data_o with 0 (silence), go SHIFT, pulse underrun_o for the tick+1 cycle.
REQ-023 SHIFT: enable_o SHALL be 1 and data_o SHALL be held constant.
REQ-024 SHIFT, done_i=1: enable_o SHALL be 0 the next cycle; go IDLE.
REQ-025 SHIFT, tick, done_i=0: tick dropped, no pop, pulse late_o for the tick+1 cycle, remain SHIFT.
REQ-026 SHIFT, tick and done_i same cycle: treated as late (REQ-025 pulse) and done (REQ-024); no pop on that tick.
REQ-027 done_i in IDLE SHALL be ignored.
REQ-028 Word latency: a sample written into an empty buffer in IDLE SHALL appear on data_o the cycle after the next tick.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; level_o SHALL never exceed FIFO_DEPTH or drop below 0.

Reset
REQ-030 While reset_i is 1: enable_o=0, data_o=0, underrun_o=0, late_o=0, level_o=0, sample_ready_o=0, FSM=IDLE, tick counter=0, pointers=0.
REQ-031 Reset asserted mid-SHIFT SHALL drop enable_o immediately (asynchronously) and discard all buffered samples.
REQ-032 After reset_i falls, the first tick SHALL occur TICK_DIV cycles later.

Verification
REQ-033 Bench uses WORD_LENGTH=16, FIFO_DEPTH=4, TICK_DIV=20 and a serializer model pulsing done_i 16 cycles after enable_o rises.
REQ-034 Write 0x1234, 0xABCD, 0x8001 after reset -> data_o shows them in order, each the cycle after successive ticks; enable_o high 16 cycles per word; level_o 3,2,1,0.
REQ-035 Hold sample_valid_i high with 6 words, no ticks yet -> 4 accepted, sample_ready_o=0 at level_o=4, words 5-6 held until a pop frees a slot.
REQ-036 Empty buffer at tick -> data_o=0x0000, enable_o=1, underrun_o single-cycle pulse; next buffered word follows on next tick.
REQ-037 Serializer model withholds done_i for 25 cycles -> late_o pulses once, no pop, level_o unchanged; next word on following tick.
REQ-038 Level 4, full, write and pop same tick cycle with sample_ready_o=0 -> no write, level_o=3; separate case at level 2 -> write+pop, level_o stays 2.
REQ-039 reset_i asserted 5 cycles into SHIFT with level_o=3 -> enable_o=0 same cycle, level_o=0, first post-reset tick after 20 cycles.

Source files
------------

// File: rtl/sample_feeder.sv
// sample_feeder: buffers producer audio samples in a small FIFO and hands one
// word per sample tick to a downstream serializer. If the buffer is empty at
// a tick, silence is sent and underrun_o pulses. If the serializer is still
// busy at a tick, that tick is dropped and late_o pulses.
module sample_feeder #(
  parameter int WORD_LENGTH      = 16,
  parameter int FIFO_DEPTH       = 8,
  parameter int SYSTEM_FREQUENCY = 100000000,
  parameter int SAMPLE_RATE      = 48000
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic [WORD_LENGTH-1:0]            sample_i,
  input  logic                              sample_valid_i,
  output logic                              sample_ready_o,
  output logic [WORD_LENGTH-1:0]            data_o,
  output logic                              enable_o,
  input  logic                              done_i,
  output logic                              underrun_o,
  output logic                              late_o,
  output logic [$clog2(FIFO_DEPTH):0]       level_o
);

  localparam int TICK_DIV = SYSTEM_FREQUENCY / SAMPLE_RATE;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W  = PTR_W + 1;
  localparam int CNT_W    = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]   TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Sample storage; contents need no reset because the pointers are reset.
  logic [WORD_LENGTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   enable_q, enable_d;
  logic                   underrun_q, underrun_d;
  logic                   late_q, late_d;

  logic                   tick;
  logic                   push;
  logic                   pop;

  // Ready depends only on reset and occupancy, never on a same-cycle pop.
  assign sample_ready_o = !reset_i && (level_q < LEVEL_FULL);
  assign push           = sample_valid_i && sample_ready_o;

  // Sample-rate tick counter: free-running 0..TICK_DIV-1, tick on the last count.
  always_comb begin
    tick  = (cnt_q == TICK_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Feeder FSM: decides pops, the word presented downstream and status pulses.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    enable_d   = enable_q;
    underrun_d = 1'b0;
    late_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        // done_i is deliberately ignored here.
        if (tick) begin
          enable_d = 1'b1;
          state_d  = SHIFT;
          if (level_q != '0) begin
            pop    = 1'b1;
            data_d = mem[rd_ptr_q];
          end else begin
            data_d     = '0;
            underrun_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        // A tick while shifting is dropped (no pop), even if done_i coincides.
        if (tick) begin
          late_d = 1'b1;
        end
        if (done_i) begin
          enable_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping; simultaneous push and pop leave the level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
  end

  // Sample storage write port.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[wr_ptr_q] <= sample_i;
    end
  end

  // State registers; reset discards buffered samples and drops enable at once.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      data_q     <= '0;
      enable_q   <= 1'b0;
      underrun_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      data_q     <= data_d;
      enable_q   <= enable_d;
      underrun_q <= underrun_d;
      late_q     <= late_d;
    end
  end

  assign data_o     = data_q;
  assign enable_o   = enable_q;
  assign underrun_o = underrun_q;
  assign late_o     = late_q;
  assign level_o    = level_q;

endmodule
